// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and address width for the SPI flash responder.
package spi_flash_pkg;

    localparam int ADDR_W = 19;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        ID,
        STATUS,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta, sync, prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash read responder (READ 03, RDSR 05, optional JEDEC ID 9F).
// Define SPI_FLASH_JEDEC_EN to answer 9F with JEDEC_ID; otherwise 9F is ignored.
//
// state  | meaning
// IDLE   | cs_n high, waiting for a cs_n fall
// CMD    | shifting in the 8-bit opcode
// ADDR   | shifting in 24 address bits, low 19 kept
// READ   | streaming memory bytes, prefetching at each byte boundary
// ID     | streaming JEDEC_ID bytes, then zeros
// STATUS | streaming STATUS_VAL
// IGNORE | unknown opcode, output disabled until cs_n rises
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID   = 24'hEF4013,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_t state, state_next;

    logic        cs_s, cs_rise, cs_fall;
    logic        sck_rise, sck_fall, sck_lvl_unused;
    logic        mosi_meta, mosi_s;
    logic        sck_r, sck_f;
    logic [4:0]  bit_cnt;
    logic [2:0]  d_cnt;
    logic [6:0]  cmd_sr;
    logic [17:0] addr_sr;
    logic [7:0]  out_sr;
    logic [7:0]  cmd_byte;
    logic [7:0]  id_byte;
    logic [1:0]  id_idx;
    logic        ld_pend;
    logic        miso_q;
    logic        cmd_done, addr_done, byte_done, shifting;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
        .clock (clock),
        .reset (reset),
        .din   (spi_sck),
        .level (sck_lvl_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clock (clock),
        .reset (reset),
        .din   (spi_cs_n),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= spi_mosi;
            mosi_s    <= mosi_meta;
        end
    end

    // Gating SCK edges with the synchronised cs_n level makes a simultaneous cs_n rise win.
    assign sck_r     = sck_rise & ~cs_s;
    assign sck_f     = sck_fall & ~cs_s;
    assign cmd_byte  = {cmd_sr, mosi_s};
    assign cmd_done  = (state == CMD)  && sck_r && (bit_cnt == 5'd7);
    assign addr_done = (state == ADDR) && sck_r && (bit_cnt == 5'd23);
    assign byte_done = sck_r && (d_cnt == 3'd7);
    assign shifting  = (state == READ) || (state == ID) || (state == STATUS);
    assign busy      = (state != IDLE);
    assign spi_miso  = spi_miso_oe & miso_q;

    always_comb begin
        id_byte = 8'h00;
        case (id_idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cs_fall) state_next = CMD;
            CMD: begin
                if (cmd_done) begin
                    case (cmd_byte)
                        CMD_READ:  state_next = ADDR;
                        CMD_RDSR:  state_next = STATUS;
`ifdef SPI_FLASH_JEDEC_EN
                        CMD_JEDEC: state_next = ID;
`else
                        CMD_JEDEC: state_next = IGNORE;
`endif
                        default:   state_next = IGNORE;
                    endcase
                end
            end
            ADDR: if (addr_done) state_next = READ;
            default: ;
        endcase
        if (cs_rise) state_next = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            d_cnt       <= '0;
            cmd_sr      <= '0;
            addr_sr     <= '0;
            out_sr      <= '0;
            id_idx      <= '0;
            ld_pend     <= 1'b0;
            miso_q      <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
        end else begin
            mem_rd  <= 1'b0;
            ld_pend <= 1'b0;
            if (cs_s) begin
                bit_cnt     <= '0;
                d_cnt       <= '0;
                miso_q      <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                ld_pend <= mem_rd;
                if (ld_pend) out_sr <= mem_rdata;
                case (state)
                    CMD: begin
                        if (sck_r) begin
                            cmd_sr  <= cmd_byte[6:0];
                            bit_cnt <= cmd_done ? 5'd0 : bit_cnt + 5'd1;
                        end
                        if (cmd_done) begin
                            id_idx <= 2'd1;
                            out_sr <= (cmd_byte == CMD_RDSR) ? STATUS_VAL : JEDEC_ID[23:16];
                        end
                    end
                    ADDR: begin
                        if (sck_r) begin
                            addr_sr <= {addr_sr[16:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        if (addr_done) begin
                            mem_addr <= {addr_sr, mosi_s};
                            mem_rd   <= 1'b1;
                        end
                    end
                    READ: begin
                        if (byte_done) begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_rd   <= 1'b1;
                        end
                    end
                    ID: begin
                        if (byte_done) begin
                            out_sr <= id_byte;
                            if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                        end
                    end
                    STATUS: if (byte_done) out_sr <= STATUS_VAL;
                    default: ;
                endcase
                if (shifting) begin
                    if (sck_r) d_cnt <= d_cnt + 3'd1;
                    if (sck_f) begin
                        spi_miso_oe <= 1'b1;
                        miso_q      <= out_sr[7];
                        out_sr      <= {out_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: stimulus pushes expected bytes/addresses, monitors pop and compare.
module tb_spi_flash_responder;

    localparam int HALF = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, mem_rd, busy;
    logic [18:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  mem [0:524287];
    logic [7:0]  tx[$];
    logic [7:0]  exp_bytes[$];
    logic [18:0] exp_addr[$];

    int vectors = 0;
    int miscompares = 0;
    int rd_count = 0;
    int oe_count = 0;
    int miso_bad = 0;
    int mbits = 0;
    logic [7:0]  mbyte = 8'h00;
    logic [7:0]  e_byte;
    logic [18:0] e_addr;

    always #5 clock = ~clock;

    spi_flash_responder #(.STATUS_VAL(8'h5C)) dut (
        .clock       (clock),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always @(posedge clock) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Master samples MISO on each SCK rise; a cs_n fall starts a fresh byte frame.
    always @(posedge spi_sck or negedge spi_cs_n) begin
        if (!spi_sck) mbits = 0;
        else if (spi_miso_oe) begin
            mbyte = {mbyte[6:0], spi_miso};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_bytes.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL miso_byte: got %02h, none expected", mbyte);
                end else begin
                    e_byte = exp_bytes.pop_front();
                    check("miso_byte", 32'(mbyte), 32'(e_byte));
                end
            end
        end
    end

    always @(negedge clock) begin
        if (spi_miso_oe) oe_count++;
        if (!spi_miso_oe && spi_miso) miso_bad++;
        if (mem_rd) begin
            rd_count++;
            if (exp_addr.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL mem_rd: got addr %05h, none expected", mem_addr);
            end else begin
                e_addr = exp_addr.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(e_addr));
            end
        end
    end

    task automatic xfer(input int nbits, input bit end_cs);
        int bi;
        logic [7:0] b;
        @(negedge clock);
        spi_sck  = 1'b0;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            bi = i / 8;
            b = (bi < tx.size()) ? tx[bi] : 8'h00;
            spi_mosi = b[7 - (i % 8)];
            repeat (HALF) @(negedge clock);
            spi_sck = 1'b1;
            if (i == nbits - 1 && end_cs) spi_cs_n = 1'b1;
            if (i != nbits - 1) begin
                repeat (HALF) @(negedge clock);
                spi_sck = 1'b0;
            end
        end
        if (end_cs) begin
            repeat (3) @(posedge clock);
            #1 check("busy_after_cs", 32'(busy), 32'd0);
            @(negedge clock);
            spi_sck = 1'b0;
            repeat (2 * HALF) @(negedge clock);
        end
    endtask

    task automatic settle(input string name, input int rd_base, input int exp_rd);
        repeat (4) @(negedge clock);
        check({name, "_rd_count"}, 32'(rd_count - rd_base), 32'(exp_rd));
        check({name, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
        check({name, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        exp_bytes.delete();
        exp_addr.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_miso"}, 32'(spi_miso), 32'd0);
        check({name, "_oe"}, 32'(spi_miso_oe), 32'd0);
        check({name, "_mem_rd"}, 32'(mem_rd), 32'd0);
        check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int rb;
        int ob;
        mem[19'h01234] = 8'hA5;
        mem[19'h01235] = 8'h5A;
        mem[19'h7FFFF] = 8'hC3;
        mem[19'h00000] = 8'h96;
        mem[19'h00010] = 8'hE1;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Plain read of two bytes; cs_n rises with the 16th data sample.
        tx = '{8'h03, 8'h00, 8'h12, 8'h34};
        exp_addr.push_back(19'h01234);
        exp_addr.push_back(19'h01235);
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h5A);
        rb = rd_count;
        xfer(48, 1'b1);
        settle("read2", rb, 2);

        // Address increment wraps at the top of the 19-bit space.
        tx = '{8'h03, 8'h07, 8'hFF, 8'hFF};
        exp_addr.push_back(19'h7FFFF);
        exp_addr.push_back(19'h00000);
        exp_bytes.push_back(8'hC3);
        exp_bytes.push_back(8'h96);
        rb = rd_count;
        xfer(48, 1'b1);
        settle("wrap", rb, 2);

        tx = '{8'h9F};
        rb = rd_count;
        ob = oe_count;
`ifdef SPI_FLASH_JEDEC_EN
        exp_bytes.push_back(8'hEF);
        exp_bytes.push_back(8'h40);
        exp_bytes.push_back(8'h13);
        exp_bytes.push_back(8'h00);
        xfer(40, 1'b1);
        check("jedec_oe_seen", 32'(oe_count > ob), 32'd1);
`else
        xfer(40, 1'b1);
        check("jedec_oe_off", 32'(oe_count - ob), 32'd0);
`endif
        settle("jedec", rb, 0);

        // Abort inside the address phase, then a status read.
        tx = '{8'h03, 8'h00, 8'h00};
        rb = rd_count;
        xfer(28, 1'b1);
        settle("abort", rb, 0);
        tx = '{8'h05};
        exp_bytes.push_back(8'h5C);
        exp_bytes.push_back(8'h5C);
        rb = rd_count;
        xfer(24, 1'b1);
        settle("status", rb, 0);

        tx = '{8'hAB};
        rb = rd_count;
        ob = oe_count;
        xfer(24, 1'b1);
        check("ignore_oe_off", 32'(oe_count - ob), 32'd0);
        settle("ignore", rb, 0);

        // Reset during the second data byte of a read.
        tx = '{8'h03, 8'h00, 8'h00, 8'h10};
        exp_addr.push_back(19'h00010);
        exp_addr.push_back(19'h00011);
        exp_bytes.push_back(8'hE1);
        rb = rd_count;
        xfer(44, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1 check_reset_outputs("midreset");
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        settle("midreset", rb, 2);

        // Upper address bits are discarded: F8_0000 maps to 0x00000.
        tx = '{8'h03, 8'hF8, 8'h00, 8'h00};
        exp_addr.push_back(19'h00000);
        exp_bytes.push_back(8'h96);
        rb = rd_count;
        xfer(40, 1'b1);
        settle("post_reset", rb, 1);

        check("miso_zero_when_oe_low", 32'(miso_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
